quad_speed_meter: RTL and testbench

QUAD_SPEED_METER -- requirements
Module: quad_speed_meter

---
 rtl/quad_speed_meter.sv | 111 +++++++++++
 tb/tb_quad_speed_meter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/quad_speed_meter.sv
// Quadrature encoder speed meter.
// Counts x4-decoded encoder steps over a fixed window of WINDOW_CYCLES clocks
// and publishes the magnitude and direction of the net count at the end of
// each window, together with a saturating count of illegal transitions.
module quad_speed_meter #(
  parameter int WINDOW_CYCLES = 50000
) (
  input  logic        theClock,
  input  logic        theReset,
  input  logic        enable,
  input  logic        encA,
  input  logic        encB,
  output logic [15:0] speed,
  output logic [7:0]  dir,
  output logic        valid,
  output logic [7:0]  errCount
);

  localparam int CW = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(WINDOW_CYCLES - 1);

  localparam logic signed [17:0] ACC_MAX = 18'sd65535;
  localparam logic signed [17:0] ACC_MIN = -18'sd65535;

  logic              r_a_meta, r_a_sync, r_b_meta, r_b_sync;
  logic [1:0]        r_prev;
  logic [CW-1:0]     r_cnt;
  logic signed [16:0] r_acc;

  logic [1:0]         w_cur;
  logic               w_fwd, w_rev, w_err, w_term, w_sat;
  logic signed [17:0] w_step, w_acc_ext, w_sum;
  logic signed [16:0] w_acc_nxt;
  logic [15:0]        w_mag;

  // Two-flop synchronizers plus previous-pair register; these run regardless
  // of enable so re-enabling never sees a stale pair.
  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      r_a_meta <= 1'b0;
      r_a_sync <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_sync <= 1'b0;
      r_prev   <= 2'b00;
    end else begin
      r_a_meta <= encA;
      r_a_sync <= r_a_meta;
      r_b_meta <= encB;
      r_b_sync <= r_b_meta;
      r_prev   <= {r_a_sync, r_b_sync};
    end
  end

  assign w_cur = {r_a_sync, r_b_sync};

  // x4 decode: forward order is 00 -> 01 -> 11 -> 10 -> 00.
  always_comb begin
    w_fwd = 1'b0;
    w_rev = 1'b0;
    unique case ({r_prev, w_cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_fwd = 1'b1;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: w_rev = 1'b1;
      default: ;
    endcase
  end

  // Both bits flipping means a transition was missed; no step is credited.
  assign w_err  = (r_prev ^ w_cur) == 2'b11;
  assign w_term = (r_cnt == TERM);

  assign w_step    = w_fwd ? 18'sd1 : (w_rev ? -18'sd1 : 18'sd0);
  assign w_acc_ext = {r_acc[16], r_acc};
  assign w_sum     = w_acc_ext + w_step;
  // A step that would cross +/-65535 is dropped rather than clipped.
  assign w_sat     = (w_sum > ACC_MAX) || (w_sum < ACC_MIN);
  assign w_acc_nxt = w_sat ? r_acc : w_sum[16:0];
  // Magnitude always fits 16 bits because the accumulator never reaches -65536.
  assign w_mag     = w_acc_nxt[16] ? (~w_acc_nxt[15:0] + 16'd1) : w_acc_nxt[15:0];

  // Window counter, accumulator and published results; the step on the
  // terminal edge belongs to the closing window.
  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      speed    <= 16'h0000;
      dir      <= 8'h00;
      valid    <= 1'b0;
      errCount <= 8'h00;
    end else if (!enable) begin
      r_cnt <= '0;
      r_acc <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (w_err && errCount != 8'hFF)
        errCount <= errCount + 8'd1;
      if (w_term) begin
        r_cnt <= '0;
        r_acc <= '0;
        speed <= w_mag;
        dir   <= {7'b0, w_acc_nxt[16]};
        valid <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        r_acc <= w_acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_quad_speed_meter.sv
// Directed bench for quad_speed_meter with a 100-cycle window. Expected
// window results are queued when a window's stimulus starts and compared
// when the meter raises valid.
module tb_quad_speed_meter;

  localparam int W = 100;

  logic        theClock, theReset, enable, encA, encB;
  logic [15:0] speed;
  logic [7:0]  dir;
  logic        valid;
  logic [7:0]  errCount;

  quad_speed_meter #(.WINDOW_CYCLES(W)) dut (
    .theClock(theClock), .theReset(theReset), .enable(enable),
    .encA(encA), .encB(encB), .speed(speed), .dir(dir),
    .valid(valid), .errCount(errCount)
  );

  initial theClock = 1'b0;
  always #5 theClock = ~theClock;

  typedef struct { int spd; int dr; } exp_t;
  exp_t q[$];

  int nchk = 0;
  int npass = 0;
  int vcount = 0;
  int p = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Scoreboard side: every valid pulse consumes one queued expectation if any.
  always @(negedge theClock) begin
    if (valid === 1'b1) begin
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("win_speed", 32'(speed), e.spd);
        check("win_dir", 32'(dir), e.dr);
      end
      vcount++;
    end
  end

  function automatic logic [1:0] gray(input int ph);
    case (ph & 3)
      0: gray = 2'b00;
      1: gray = 2'b01;
      2: gray = 2'b11;
      default: gray = 2'b10;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge theClock); #2; end
  endtask

  task automatic push(input int s, input int d);
    exp_t e;
    e.spd = s; e.dr = d;
    q.push_back(e);
  endtask

  task automatic fwd(input int n);
    repeat (n) begin p = (p + 1) & 3; {encA, encB} = gray(p); tick(2); end
  endtask

  task automatic rev(input int n);
    repeat (n) begin p = (p + 3) & 3; {encA, encB} = gray(p); tick(2); end
  endtask

  task automatic toggle_both(input int n);
    repeat (n) begin {encA, encB} = ~{encA, encB}; p = (p + 2) & 3; tick(2); end
  endtask

  // Returns just after the first clock edge of the next window.
  task automatic align();
    int c0;
    int k;
    c0 = vcount;
    k = 0;
    while (vcount == c0 && k < 3 * W) begin tick(1); k++; end
    check("align_timeout", 32'(vcount != c0), 32'd1);
  endtask

  initial begin
    int c0;
    int k;
    theReset = 1'b0; enable = 1'b0; encA = 1'b0; encB = 1'b0;
    tick(3);
    check("rst_speed", 32'(speed), 0);
    check("rst_dir", 32'(dir), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_err", 32'(errCount), 0);
    theReset = 1'b1;
    tick(3);

    // First valid exactly W cycles after enable; empty window.
    enable = 1'b1;
    tick(W - 1);
    check("first_valid_early", 32'(valid), 0);
    tick(1);
    check("first_valid", 32'(valid), 1);
    check("first_speed", 32'(speed), 0);
    tick(1);

    // 40 forward steps.
    push(40, 0); fwd(40); align();
    // 25 reverse steps.
    push(25, 1); rev(25); align();
    // Net zero.
    push(0, 0); fwd(10); rev(10); align();

    // Illegal transitions: 3, then saturate.
    push(0, 0);
    toggle_both(3);
    tick(5);
    check("err3", 32'(errCount), 3);
    align();
    toggle_both(300);
    tick(5);
    check("err_sat", 32'(errCount), 8'hFF);
    align();

    // Step landing on the terminal edge belongs to the closing window.
    push(1, 0);
    tick(W - 4);
    fwd(1);
    align();
    push(0, 0);
    align();

    // Nonzero result so retention during disable is observable.
    push(7, 1); rev(7); align();

    // Drop enable at cycle 50 of a window with 20 steps.
    fwd(20);
    tick(9);
    enable = 1'b0;
    c0 = vcount;
    tick(150);
    check("dis_no_valid", 32'(vcount), c0);
    check("dis_speed", 32'(speed), 7);
    check("dis_dir", 32'(dir), 1);
    push(0, 0);
    enable = 1'b1;
    tick(W - 1);
    check("reen_valid_early", 32'(valid), 0);
    tick(1);
    check("reen_valid", 32'(valid), 1);
    tick(1);

    // Bring the encoder back to phase 00 before the reset test.
    k = ((4 - p) & 3) + 4;
    push(k, 0); fwd(k); align();
    check("pre_rst_speed", 32'(speed), k);
    fwd(3);
    tick(10);
    #3 theReset = 1'b0;
    #1;
    check("arst_speed", 32'(speed), 0);
    check("arst_dir", 32'(dir), 0);
    check("arst_valid", 32'(valid), 0);
    check("arst_err", 32'(errCount), 0);
    // Leave the encoder at 00 so release sees no transition.
    fwd(1);
    check("enc_phase0", 32'({encA, encB}), 0);
    theReset = 1'b1;
    push(0, 0);
    tick(W - 1);
    check("rst_full_window_early", 32'(valid), 0);
    tick(1);
    check("rst_full_window", 32'(valid), 1);
    tick(1);
    push(6, 1); rev(6); align();
    check("queue_drained", 32'(q.size()), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
